// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM responder stand-in.
package sdram_pkg;
  localparam int DEFAULT_ADDR_W   = 26;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int MAX_READ_LATENCY = 8;

  localparam logic [DEFAULT_DATA_W-1:0] ERR_PATTERN = 32'hDEADBEEF;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_DATA_W-1:0] data;
  } rd_slot_t;
endpackage

// File: rtl/sdram_responder_if.sv
// Request/response bus between the custom logic's SDRAM master and the responder.
interface sdram_responder_if #(
  parameter int ADDR_W = sdram_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = sdram_pkg::DEFAULT_DATA_W
) ();
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              datareadvalid;

  modport master (
    output read_en, write_en, address, write_data,
    input  read_data, datareadvalid
  );

  modport slave (
    input  read_en, write_en, address, write_data,
    output read_data, datareadvalid
  );
endinterface

// File: rtl/read_latency_pipe.sv
// Fixed-depth shift register carrying captured read words toward the response port.
module read_latency_pipe
  import sdram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     n_rst,
  input  rd_slot_t slot_i,
  output rd_slot_t slot_o
);
  rd_slot_t stage_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= slot_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign slot_o = stage_q[DEPTH-1];
endmodule

// File: rtl/sdram_responder.sv
// Memory-side responder: address decode, word array, fixed-latency reads,
// sticky protocol-error flag and saturating request counters.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int              ADDR_W       = DEFAULT_ADDR_W,
  parameter int              DATA_W       = DEFAULT_DATA_W,
  parameter int              MEM_WORDS    = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int              READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  sdram_responder_if.slave  bus,
  input  logic              clear_counts,
  output logic              err_flag,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("sdram_responder: READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
  end
  if (DATA_W != DEFAULT_DATA_W) begin : g_bad_data_w
    $error("sdram_responder: DATA_W must match the read slot width");
  end
  if ((1 << IDX_W) != MEM_WORDS) begin : g_bad_mem_words
    $error("sdram_responder: MEM_WORDS must be a power of two");
  end

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_issue;
  logic              proto_err;

  assign offset    = bus.address - BASE_ADDR;
  assign in_range  = (bus.address >= BASE_ADDR) && (offset < ADDR_W'(MEM_WORDS));
  assign idx       = offset[IDX_W-1:0];
  assign rd_issue  = bus.read_en && !bus.write_en;
  assign proto_err = (bus.read_en || bus.write_en) &&
                     (!in_range || (bus.read_en && bus.write_en));

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // NOTE: the array has no reset; contents survive n_rst and cost no reset fan-out.
  always_ff @(posedge clk) begin
    if (bus.write_en && in_range) mem_q[idx] <= bus.write_data;
  end

  rd_slot_t slot_in, slot_out;

  assign slot_in.valid = rd_issue;
  assign slot_in.data  = in_range ? mem_q[idx] : ERR_PATTERN;

  read_latency_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
    .clk    (clk),
    .n_rst  (n_rst),
    .slot_i (slot_in),
    .slot_o (slot_out)
  );

  // The last returned word is held here so read_data is stable between pulses.
  logic [DATA_W-1:0] last_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              last_q <= '0;
    else if (slot_out.valid) last_q <= slot_out.data;
  end

  assign bus.datareadvalid = slot_out.valid;
  assign bus.read_data     = slot_out.valid ? slot_out.data : last_q;

  logic        err_q, err_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (clear_counts) begin
      err_d    = 1'b0;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (proto_err)                       err_d    = 1'b1;
      if (rd_issue && rd_cnt_q != '1)      rd_cnt_d = rd_cnt_q + 16'd1;
      if (bus.write_en && wr_cnt_q != '1)  wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign err_flag    = err_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Randomised bench for sdram_responder, scored against a transaction-level model.
module tb_sdram_responder;
  import sdram_pkg::*;

  localparam int          L     = 2;
  localparam int          MEM   = 4096;
  localparam logic [25:0] BASE  = 26'd0;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear_counts = 1'b0;
  logic        err_flag;
  logic [15:0] read_count, write_count;

  always #5 clk = ~clk;

  sdram_responder_if #(.ADDR_W(26), .DATA_W(32)) bus ();

  sdram_responder #(
    .ADDR_W(26), .DATA_W(32), .MEM_WORDS(MEM), .BASE_ADDR(BASE), .READ_LATENCY(L)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bus          (bus),
    .clear_counts (clear_counts),
    .err_flag     (err_flag),
    .read_count   (read_count),
    .write_count  (write_count)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int valid_seen = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [int];
  logic        ref_err;
  int          ref_rd_n, ref_wr_n;
  logic [31:0] ref_last;

  function automatic bit ref_in_range(logic [25:0] a);
    return (a >= BASE) && (int'(a - BASE) < MEM);
  endfunction

  function automatic logic [15:0] sat16(int n);
    return 16'((n > 65535) ? 65535 : n);
  endfunction

  task automatic ref_reset();
    pend.delete();
    ref_err  = 1'b0;
    ref_rd_n = 0;
    ref_wr_n = 0;
    ref_last = 32'h0;
  endtask

  // One clock of stimulus; the model is advanced for that edge and the response port scored.
  task automatic step(bit rd, bit wr, logic [25:0] a, logic [31:0] d, bit clr);
    bit exp_v;
    bus.read_en    = rd;
    bus.write_en   = wr;
    bus.address    = a;
    bus.write_data = d;
    clear_counts   = clr;
    @(posedge clk);
    edge_cnt++;
    if (rd && !wr) begin
      resp_t r;
      r.due  = edge_cnt + L - 1;
      r.data = !ref_in_range(a) ? 32'hDEADBEEF : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
      pend.push_back(r);
    end
    if (wr && ref_in_range(a)) ref_mem[int'(a)] = d;
    if (clr) begin
      ref_err = 1'b0; ref_rd_n = 0; ref_wr_n = 0;
    end else begin
      if ((rd || wr) && (!ref_in_range(a) || (rd && wr))) ref_err = 1'b1;
      if (rd && !wr) ref_rd_n++;
      if (wr) ref_wr_n++;
    end
    #1;
    bus.read_en = 1'b0; bus.write_en = 1'b0; clear_counts = 1'b0;
    exp_v = (pend.size() > 0) && (pend[0].due == edge_cnt);
    if (bus.datareadvalid === 1'b1) valid_seen++;
    checks++;
    if (bus.datareadvalid !== exp_v) begin
      errors++;
      $display("FAIL valid@edge%0d: got %b expected %b", edge_cnt, bus.datareadvalid, exp_v);
    end
    if (exp_v) begin
      ref_last = pend[0].data;
      void'(pend.pop_front());
    end
    checks++;
    if (bus.read_data !== ref_last) begin
      errors++;
      $display("FAIL read_data@edge%0d: got %h expected %h", edge_cnt, bus.read_data, ref_last);
    end
    checks++;
    if (err_flag !== ref_err || read_count !== sat16(ref_rd_n) || write_count !== sat16(ref_wr_n)) begin
      errors++;
      $display("FAIL status@edge%0d: got err=%b rc=%h wc=%h expected err=%b rc=%h wc=%h",
               edge_cnt, err_flag, read_count, write_count, ref_err, sat16(ref_rd_n), sat16(ref_wr_n));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 26'd0, 32'd0, 1'b0);
  endtask

  task automatic check_all_zero(string tag);
    checks++;
    if (bus.read_data !== 32'h0 || bus.datareadvalid !== 1'b0 || err_flag !== 1'b0 ||
        read_count !== 16'h0 || write_count !== 16'h0) begin
      errors++;
      $display("FAIL %s: got rd=%h v=%b err=%b rc=%h wc=%h expected all zero", tag,
               bus.read_data, bus.datareadvalid, err_flag, read_count, write_count);
    end
  endtask

  task automatic test_reset();
    bus.read_en = 1'b0; bus.write_en = 1'b0; bus.address = '0; bus.write_data = '0;
    n_rst = 1'b0;
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_write_read();
    int v0 = valid_seen;
    step(1'b0, 1'b1, 26'd5, 32'h11223344, 1'b0);
    step(1'b1, 1'b0, 26'd5, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (valid_seen - v0 != 1 || bus.read_data !== 32'h11223344 || write_count !== 16'd1 ||
        read_count !== 16'd1 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL write_read: got pulses=%0d rd=%h wc=%0d rc=%0d err=%b expected 1 11223344 1 1 0",
               valid_seen - v0, bus.read_data, write_count, read_count, err_flag);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 26'(i), 32'hA0 + 32'(i), 1'b0);
    v0 = valid_seen;
    for (int i = 3; i >= 0; i--) step(1'b1, 1'b0, 26'(i), 32'h0, 1'b0);
    idle(4);
    checks++;
    if (valid_seen - v0 != 4 || bus.read_data !== 32'hA0) begin
      errors++;
      $display("FAIL back_to_back: got pulses=%0d rd=%h expected 4 000000a0", valid_seen - v0, bus.read_data);
    end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 1'b0, 26'd4096, 32'h0, 1'b0);
    idle(2);
    checks++;
    if (err_flag !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oor_read: got err=%b rd=%h expected 1 deadbeef", err_flag, bus.read_data);
    end
    step(1'b0, 1'b1, 26'd4096, 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, 26'd0, 32'h0, 1'b0);
    idle(2);
    checks++;
    if (bus.read_data !== 32'hA0) begin
      errors++;
      $display("FAIL oor_write_alias: got %h expected 000000a0", bus.read_data);
    end
  endtask

  task automatic test_simultaneous();
    int v0;
    step(1'b0, 1'b0, 26'd0, 32'h0, 1'b1);
    v0 = valid_seen;
    step(1'b1, 1'b1, 26'd7, 32'h55, 1'b0);
    idle(3);
    checks++;
    if (valid_seen != v0 || err_flag !== 1'b1 || write_count !== 16'd1 || read_count !== 16'd0) begin
      errors++;
      $display("FAIL simultaneous: got pulses=%0d err=%b wc=%0d rc=%0d expected 0 1 1 0",
               valid_seen - v0, err_flag, write_count, read_count);
    end
    step(1'b1, 1'b0, 26'd7, 32'h0, 1'b0);
    idle(2);
    checks++;
    if (bus.read_data !== 32'h55) begin
      errors++;
      $display("FAIL simultaneous_data: got %h expected 00000055", bus.read_data);
    end
  endtask

  task automatic test_reset_midflight();
    int v0 = valid_seen;
    step(1'b1, 1'b0, 26'd2, 32'h0, 1'b0);
    n_rst = 1'b0;
    #1;
    ref_reset();
    check_all_zero("reset_async");
    repeat (2) begin
      @(posedge clk);
      edge_cnt++;
      if (bus.datareadvalid === 1'b1) valid_seen++;
    end
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    n_rst = 1'b1;
    idle(5);
    checks++;
    if (valid_seen != v0) begin
      errors++;
      $display("FAIL reset_drop: got %0d pulses expected 0", valid_seen - v0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 26'(i), $urandom, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [25:0] a;
      a = ($urandom_range(0, 9) == 0) ? 26'(4096 + $urandom_range(0, 4)) : 26'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, $urandom,
           1'($urandom_range(0, 19) == 0));
    end
    idle(L + 1);
  endtask

  task automatic test_saturate_clear();
    int v0;
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 26'($urandom_range(0, 15)), $urandom, 1'b0);
    checks++;
    if (write_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: got wc=%h expected ffff", write_count);
    end
    v0 = valid_seen;
    step(1'b1, 1'b0, 26'd3, 32'h0, 1'b1);
    checks++;
    if (write_count !== 16'h0 || read_count !== 16'h0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL clear: got wc=%h rc=%h err=%b expected 0 0 0", write_count, read_count, err_flag);
    end
    idle(2);
    checks++;
    if (valid_seen - v0 != 1 || bus.read_data !== ref_mem[3]) begin
      errors++;
      $display("FAIL clear_read: got pulses=%0d rd=%h expected 1 %h", valid_seen - v0, bus.read_data, ref_mem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    test_saturate_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
Memory-side responder for the custom logic's SDRAM master port. It accepts single-cycle read and write requests (read_en/write_en, 26-bit address, 32-bit data) and stores words in an internal array. Read data is returned after a fixed, parameterised latency with a one-cycle datareadvalid pulse. It is the simulation and bring-up stand-in for the external SDRAM controller, with sticky protocol-error detection and request counters for debug.

Parameters:
ADDR_W, 26, address width.
DATA_W, 32, data width.
MEM_WORDS, 4096, number of stored words (power of two).
BASE_ADDR, 26'd0, first word address mapped to the array.
READ_LATENCY, 2, cycles from request sample to datareadvalid; legal range 1..8.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
read_en  input  1  read request, sampled every rising edge.
write_en  input  1  write request, sampled every rising edge.
address  input  ADDR_W  word address of the request.
write_data  input  DATA_W  data to store when write_en is high.
read_data  output  DATA_W  returned read word.
datareadvalid  output  1  single-cycle pulse qualifying read_data.
err_flag  output  1  sticky protocol/range error.
read_count  output  16  accepted read requests, saturating.
write_count  output  16  accepted write requests, saturating.
clear_counts  input  1  synchronous clear of counters and err_flag.

Behaviour:
- Reset (async, n_rst=0) state:
  - read_data=0, datareadvalid=0, err_flag=0, read_count=0, write_count=0.
  - All latency-pipeline valid bits cleared.
  - Array contents are not reset.
- No backpressure: one request is accepted per cycle, every cycle. There is no waitrequest.
- Address decode: offset = address - BASE_ADDR, computed in ADDR_W bits. The request is in range iff address >= BASE_ADDR and offset < MEM_WORDS. Array index = offset[log2(MEM_WORDS)-1:0].
- Write (write_en=1, read_en=0), sampled at edge N:
  - In range: array[index] <= write_data at edge N.
  - Out of range: data discarded, err_flag <= 1.
  - write_count increments in both cases.
- Read (read_en=1, write_en=0), sampled at edge N:
  - The array word is captured into the pipeline at edge N.
  - datareadvalid=1 and read_data=word during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, the response is visible in the cycle immediately following edge N.
  - Out of range: the response still occurs with the same timing, carrying 32'hDEADBEEF, and err_flag <= 1.
  - read_count increments in both cases.
- Ordering and pipelining:
  - Back-to-back reads produce back-to-back valid pulses in issue order.
  - A write at edge N is visible to a read sampled at edge N+1 or later.
  - A read captures data at issue, so writes made while the read is in flight do not alter it.
- read_data holds its last returned value while datareadvalid=0.
- Simultaneous read_en and write_en: the write is performed as above, no read is issued (no valid pulse results), err_flag <= 1, and only write_count increments.
- Counters saturate at 16'hFFFF (no wrap).
- clear_counts=1 at an edge:
  - Counters and err_flag become 0.
  - A request sampled on the same edge is not counted and does not set err_flag.
  - The request itself is still serviced.
- Reset mid-operation: in-flight reads are dropped. No datareadvalid is produced for requests issued before reset.
- READ_LATENCY outside 1..8 is an elaboration error.

Decomposition:
- Package sdram_pkg:
  - ADDR_W and DATA_W defaults.
  - ERR_PATTERN = 32'hDEADBEEF.
  - MAX_READ_LATENCY = 8.
  - Typedef rd_slot_t {logic valid; logic [DATA_W-1:0] data}.
- Sub-module read_latency_pipe: parameterised-depth shift register of rd_slot_t with async active-low reset. Its output drives datareadvalid and the read_data load enable.
- The top level holds the address decode, the array, error logic and counters.

Test Plan:
1. Write 0x11223344 to address 5, then read address 5 on the next cycle (READ_LATENCY=2) -> datareadvalid pulses exactly once, 2 cycles after the read sample, read_data=0x11223344; write_count=1, read_count=1, err_flag=0.
2. Write addresses 0..3 with 0xA0..0xA3, then issue 4 back-to-back reads of 3,2,1,0 -> 4 consecutive valid pulses carrying 0xA3,0xA2,0xA1,0xA0; read_data holds 0xA0 afterwards.
3. Read address 4096 (MEM_WORDS=4096, BASE_ADDR=0) -> valid pulse with 0xDEADBEEF, err_flag=1; write to 4096 -> array unchanged (read of 0 still returns the old value).
4. read_en=write_en=1 at address 7 with data 0x55 -> no valid pulse, array[7]=0x55 (verified by a later read), err_flag=1, write_count+1, read_count unchanged.
5. Issue a read, then assert n_rst=0 one cycle later for 2 cycles -> no datareadvalid ever appears; all outputs 0 after reset.
6. Drive 70000 writes -> write_count=16'hFFFF; then clear_counts=1 together with a read -> counts=0, err_flag=0, and the read still returns valid data.
